// File: rtl/serial_subtractor.sv
// Bit-serial A - B - BIN, LSB first, one full-subtractor cell.
// start/busy/done handshake; result and final borrow held until next start.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             serial_d,
  output logic             serial_valid
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             nb;
  logic             last;

  assign d    = a_sr[0] ^ b_sr[0] ^ brw;
  assign nb   = (~a_sr[0] & b_sr[0]) |
                (~(a_sr[0] ^ b_sr[0]) & brw);
  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // The last bit's valid cycle coincides with DONE, where valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr         <= '0;
      b_sr         <= '0;
      brw          <= 1'b0;
      cnt          <= '0;
      diff         <= '0;
      borrow_out   <= 1'b0;
      serial_d     <= 1'b0;
      serial_valid <= 1'b0;
    end else begin
      serial_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr       <= a;
            b_sr       <= b;
            brw        <= borrow_in;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
          end
        end
        RUN: begin
          diff         <= {d, diff[WIDTH-1:1]};
          a_sr         <= a_sr >> 1;
          b_sr         <= b_sr >> 1;
          brw          <= nb;
          serial_d     <= d;
          serial_valid <= ~last;
          if (last) borrow_out <= nb;
          else      cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Table vectors, random ops against arithmetic model, handshake corners.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         serial_d;
  logic         serial_valid;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a            (a),
    .b            (b),
    .borrow_in    (borrow_in),
    .busy         (busy),
    .done         (done),
    .diff         (diff),
    .borrow_out   (borrow_out),
    .serial_d     (serial_d),
    .serial_valid (serial_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] ed;
    logic         eb;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic [W-1:0] ed,
                        input logic eb, input bit inject);
    logic [W-1:0] sbits;
    int ndone, dedge, nbusy, nsv, novl;
    sbits = '0;
    ndone = 0;
    dedge = -1;
    nsv   = 0;
    novl  = 0;
    @(negedge clk);
    a = ia; b = ib; borrow_in = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("diff_cleared", diff, 0);
    chk("bout_cleared", borrow_out, 0);
    nbusy = 1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k <= W) sbits[k-1] = serial_d;
      if (busy) nbusy++;
      if (serial_valid) nsv++;
      if (done && busy) novl++;
      if (done) begin
        ndone++;
        if (dedge < 0) dedge = k;
      end
      if (inject && k == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; borrow_in = 1'b1;
      end
      if (inject && k == 4) start = 1'b0;
    end
    chk("done_count", ndone, 1);
    chk("done_edge", dedge, W);
    chk("busy_cycles", nbusy, W);
    chk("valid_cycles", nsv, W - 1);
    chk("done_busy_overlap", novl, 0);
    chk("diff", diff, ed);
    chk("borrow_out", borrow_out, eb);
    chk("serial_bits", sbits, ed);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int q[$];
    int nd, ovl;
    logic [W-1:0] ra, rb;
    logic         rbin;
    logic [W:0]   full;

    tbl[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    tbl[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1};
    tbl[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    #2;
    chk("reset_outputs",
        {busy, done, diff, borrow_out, serial_d, serial_valid}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].ed, tbl[i].eb, 1'b0);

    // start and operand changes mid-run must be ignored
    run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b1);

    // reset in the 4th RUN cycle aborts asynchronously
    @(negedge clk);
    a = 8'h5A; b = 8'h23; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_outputs",
        {busy, done, diff, borrow_out, serial_d, serial_valid}, 0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("no_done_after_abort", nd, 0);
    run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      run_op(ra, rb, rbin, full[W-1:0],
             ({1'b0, ra} < {1'b0, rb} + {{W{1'b0}}, rbin}), 1'b0);
    end

    // start held high: back-to-back ops spaced WIDTH+2 edges
    @(negedge clk);
    a = 8'h03; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
    ovl = 0;
    for (int e = 0; e < 42; e++) begin
      @(posedge clk); #1;
      if (done && busy) ovl++;
      if (done) begin
        q.push_back(e);
        chk("hold_diff", diff, 8'h02);
      end
    end
    start = 1'b0;
    chk("hold_overlap", ovl, 0);
    chk("hold_done_count", q.size(), 4);
    for (int i = 1; i < q.size(); i++)
      chk("hold_spacing", q[i] - q[i-1], W + 2);
    repeat (12) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
